// File: rtl/down_timer.sv
// Programmable down-counting timer with prescaler, one-shot and auto-reload modes.
// Counts a loaded value down to zero and pulses tc at terminal count.
module down_timer #(
   parameter int WIDTH = 4,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [PRE_W-1:0] prescale,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             tc,
   output logic             expired
);

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   logic             state;
   logic [WIDTH-1:0] reload;
   logic [PRE_W-1:0] pre_cnt;

   assign busy = (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         q       <= '0;
         reload  <= '0;
         pre_cnt <= '0;
         tc      <= 1'b0;
         expired <= 1'b0;
      end else begin
         tc <= 1'b0;
         if (load) begin
            q       <= load_val;
            reload  <= load_val;
            pre_cnt <= '0;
            state   <= IDLE;
            expired <= 1'b0;
         end else if (stop) begin
            if (state == RUN) begin
               state   <= IDLE;
               pre_cnt <= '0;
            end
         end else if (state == IDLE) begin
            if (start && q != '0) begin
               state   <= RUN;
               pre_cnt <= '0;
               expired <= 1'b0;
            end
         end else if (pre_cnt >= prescale) begin
            // >= rather than == so a mid-run prescale reduction cannot stall
            pre_cnt <= '0;
            if (q > WIDTH'(1)) begin
               q <= q - WIDTH'(1);
            end else if (q == WIDTH'(1)) begin
               tc <= 1'b1;
               if (auto_reload) begin
                  q <= reload;
               end else begin
                  q       <= '0;
                  expired <= 1'b1;
                  state   <= IDLE;
               end
            end else begin
               state <= IDLE;
            end
         end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer: reset, one-shot, prescaler,
// periodic, pause/resume, priority corner cases and reset mid-run.
module tb_down_timer;

   logic       clk = 1'b0;
   logic       reset, load, start, stop, auto_reload;
   logic [3:0] load_val, prescale;
   logic [3:0] q;
   logic       busy, tc, expired;

   int pass_cnt = 0;
   int total_cnt = 0;

   down_timer #(.WIDTH(4), .PRE_W(4)) dut (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .prescale(prescale), .start(start), .stop(stop),
      .auto_reload(auto_reload), .q(q), .busy(busy), .tc(tc),
      .expired(expired)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] v, input logic [3:0] p, input logic ar);
      load_val = v; prescale = p; auto_reload = ar; load = 1'b1;
      cyc();
      load = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      total_cnt++;
      if ({q, busy, tc, expired} !== 7'b0)
         $display("FAIL reset: q=%0d busy=%b tc=%b exp=%b, want all 0", q, busy, tc, expired);
      else pass_cnt++;
   endtask

   task automatic test_oneshot();
      do_load(4'd5, 4'd0, 1'b0);
      do_start();
      total_cnt++;
      if (q !== 4'd5 || busy !== 1'b1)
         $display("FAIL oneshot_start: q=%0d busy=%b, want q=5 busy=1", q, busy);
      else pass_cnt++;
      for (int i = 4; i >= 0; i--) begin
         cyc();
         total_cnt++;
         if (q !== 4'(i) || tc !== (i == 0) || busy !== (i != 0) || expired !== (i == 0))
            $display("FAIL oneshot_step%0d: q=%0d tc=%b busy=%b exp=%b, want q=%0d tc=%b busy=%b exp=%b",
                     i, q, tc, busy, expired, i, i == 0, i != 0, i == 0);
         else pass_cnt++;
      end
      cyc();
      total_cnt++;
      if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || expired !== 1'b1)
         $display("FAIL oneshot_after: q=%0d tc=%b busy=%b exp=%b, want 0 0 0 1", q, tc, busy, expired);
      else pass_cnt++;
   endtask

   task automatic test_prescaler();
      int         tc_seen;
      logic [3:0] exp_q;
      tc_seen = 0;
      do_load(4'd3, 4'd2, 1'b0);
      do_start();
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (tc) tc_seen++;
         exp_q = (k >= 9) ? 4'd0 : 4'(3 - k / 3);
         total_cnt++;
         if (q !== exp_q || tc !== (k == 9) || busy !== (k < 9) || expired !== (k >= 9))
            $display("FAIL prescale_k%0d: q=%0d tc=%b busy=%b exp=%b, want q=%0d tc=%b busy=%b exp=%b",
                     k, q, tc, busy, expired, exp_q, k == 9, k < 9, k >= 9);
         else pass_cnt++;
      end
      total_cnt++;
      if (tc_seen != 1)
         $display("FAIL prescale_tc_count: got %0d pulses, want 1", tc_seen);
      else pass_cnt++;
   endtask

   task automatic test_periodic();
      logic [3:0] exp_q;
      do_load(4'd4, 4'd0, 1'b1);
      do_start();
      for (int k = 1; k <= 12; k++) begin
         cyc();
         exp_q = (k % 4 == 0) ? 4'd4 : 4'(4 - k % 4);
         total_cnt++;
         if (q !== exp_q || tc !== (k % 4 == 0) || busy !== 1'b1 || expired !== 1'b0)
            $display("FAIL periodic_k%0d: q=%0d tc=%b busy=%b exp=%b, want q=%0d tc=%b busy=1 exp=0",
                     k, q, tc, busy, expired, exp_q, k % 4 == 0);
         else pass_cnt++;
      end
      // reload of 1 with no prescale holds tc high continuously
      do_load(4'd1, 4'd0, 1'b1);
      do_start();
      for (int k = 1; k <= 4; k++) begin
         cyc();
         total_cnt++;
         if (q !== 4'd1 || tc !== 1'b1 || busy !== 1'b1)
            $display("FAIL periodic_one_k%0d: q=%0d tc=%b busy=%b, want q=1 tc=1 busy=1", k, q, tc, busy);
         else pass_cnt++;
      end
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || expired !== 1'b0)
         $display("FAIL periodic_stop: busy=%b exp=%b, want 0 0", busy, expired);
      else pass_cnt++;
   endtask

   task automatic test_pause();
      do_load(4'd6, 4'd0, 1'b0);
      do_start();
      repeat (4) cyc();
      total_cnt++;
      if (q !== 4'd2 || busy !== 1'b1)
         $display("FAIL pause_pre: q=%0d busy=%b, want q=2 busy=1", q, busy);
      else pass_cnt++;
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) cyc();
         total_cnt++;
         if (q !== 4'd2 || busy !== 1'b0 || tc !== 1'b0)
            $display("FAIL pause_hold%0d: q=%0d busy=%b tc=%b, want q=2 busy=0 tc=0", k, q, busy, tc);
         else pass_cnt++;
      end
      do_start();
      total_cnt++;
      if (q !== 4'd2 || busy !== 1'b1)
         $display("FAIL resume_start: q=%0d busy=%b, want q=2 busy=1", q, busy);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (q !== 4'd1 || tc !== 1'b0)
         $display("FAIL resume_1: q=%0d tc=%b, want q=1 tc=0", q, tc);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (q !== 4'd0 || tc !== 1'b1 || busy !== 1'b0 || expired !== 1'b1)
         $display("FAIL resume_0: q=%0d tc=%b busy=%b exp=%b, want 0 1 0 1", q, tc, busy, expired);
      else pass_cnt++;
   endtask

   task automatic test_priority();
      int tc_seen;
      // load beats start in the same cycle
      load_val = 4'd7; prescale = 4'd0; auto_reload = 1'b0;
      load = 1'b1; start = 1'b1;
      cyc();
      load = 1'b0; start = 1'b0;
      total_cnt++;
      if (q !== 4'd7 || busy !== 1'b0)
         $display("FAIL load_start: q=%0d busy=%b, want q=7 busy=0", q, busy);
      else pass_cnt++;
      // start with q == 0 is ignored
      do_load(4'd0, 4'd0, 1'b0);
      do_start();
      total_cnt++;
      if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
         $display("FAIL start_zero: q=%0d busy=%b tc=%b, want 0 0 0", q, busy, tc);
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (tc !== 1'b0 || busy !== 1'b0)
         $display("FAIL start_zero_after: tc=%b busy=%b, want 0 0", tc, busy);
      else pass_cnt++;
      // stop beats start in RUN
      do_load(4'd5, 4'd0, 1'b0);
      do_start();
      stop = 1'b1; start = 1'b1;
      cyc();
      stop = 1'b0; start = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || q !== 4'd5)
         $display("FAIL stop_start: busy=%b q=%0d, want busy=0 q=5", busy, q);
      else pass_cnt++;
      // maximum load value
      tc_seen = 0;
      do_load(4'd15, 4'd0, 1'b0);
      do_start();
      for (int k = 1; k <= 15; k++) begin
         cyc();
         if (tc && k < 15) tc_seen++;
      end
      total_cnt++;
      if (tc !== 1'b1 || q !== 4'd0 || tc_seen != 0)
         $display("FAIL max_load: tc=%b q=%0d early_tc=%0d, want tc=1 q=0 early_tc=0", tc, q, tc_seen);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_load(4'd5, 4'd0, 1'b1);
      do_start();
      cyc();
      cyc();
      total_cnt++;
      if (q !== 4'd3 || busy !== 1'b1)
         $display("FAIL reset_mid_pre: q=%0d busy=%b, want q=3 busy=1", q, busy);
      else pass_cnt++;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      total_cnt++;
      if ({q, busy, tc, expired} !== 7'b0)
         $display("FAIL reset_mid: q=%0d busy=%b tc=%b exp=%b, want all 0", q, busy, tc, expired);
      else pass_cnt++;
      do_start();
      cyc();
      total_cnt++;
      if (q !== 4'd0 || busy !== 1'b0 || tc !== 1'b0)
         $display("FAIL reset_mid_start: q=%0d busy=%b tc=%b, want 0 0 0", q, busy, tc);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
      auto_reload = 1'b0; load_val = 4'd0; prescale = 4'd0;
      #2;
      test_reset();
      test_oneshot();
      test_prescaler();
      test_periodic();
      test_pause();
      test_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer: the counterpart of the free-running up counter. It loads a value, counts it down to zero at a prescaled rate, and flags terminal count. It runs in one-shot or auto-reload mode and sits beside the up counter as the system's interval and timeout source.

## Interface
- WIDTH, 4, count width in bits.
- PRE_W, 4, prescaler width in bits.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- load  in  1  capture load_val into the count and the reload register.
- load_val  in  WIDTH  start/reload value.
- prescale  in  PRE_W  one count tick every prescale+1 clocks.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting; q is held.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot mode.
- q  out  WIDTH  current count.
- busy  out  1  high while in RUN.
- tc  out  1  one-cycle terminal-count pulse.
- expired  out  1  sticky one-shot completion flag.

## Operation
- States: IDLE, RUN.
- Internal registers: reload (WIDTH bits), pre_cnt (PRE_W bits).
- Reset: every internal register and every output goes to zero; state = IDLE. Reset overrides all other inputs.
- Input priority each cycle: reset > load > stop > start.
- load (any state):
  - q <= load_val; reload <= load_val; pre_cnt <= 0.
  - state <= IDLE; expired <= 0; tc <= 0.
  - A start in the same cycle is ignored.
- start in IDLE with q != 0: state <= RUN; pre_cnt <= 0; expired <= 0.
- start in IDLE with q == 0: ignored. No tc pulse, no state change.
- start while already in RUN: ignored.
- stop in RUN: state <= IDLE; q is held; pre_cnt <= 0. A later start resumes counting from the held q.
- stop in IDLE: no effect.
- RUN, no tick (pre_cnt < prescale): pre_cnt increments.
- RUN, tick (pre_cnt >= prescale):
  - pre_cnt <= 0.
  - The >= comparison ensures a mid-run reduction of prescale cannot stall the timer.
- Tick with q > 1: q <= q - 1.
- Tick with q == 1, one-shot (auto_reload == 0 at the tick):
  - q <= 0; tc <= 1; expired <= 1; state <= IDLE.
- Tick with q == 1, periodic (auto_reload == 1 at the tick):
  - q <= reload; tc <= 1; state stays RUN.
- Non-tick cycles: tc <= 0, so tc is never high on two consecutive cycles when prescale > 0.
- prescale == 0, periodic mode, reload == 1: tc stays high continuously.
- Arithmetic is unsigned. q never wraps below 0. load_val = 2^WIDTH-1 is legal.

## Timing
- All outputs are registered. busy is high exactly while the state is RUN.
- start accepted on edge N: busy = 1 after edge N.
- First decrement occurs on edge N + prescale + 1.
- One-shot from loaded value L:
  - tc and expired rise on edge N + L*(prescale+1).
  - busy falls on that same edge.
  - q == 0 in the cycle tc is high.
- Periodic mode: tc pulses every reload*(prescale+1) cycles after the first terminal count, with no gap cycle.
- stop on edge M: q is frozen from edge M onward.
- Resume on edge R: the next decrement occurs on edge R + prescale + 1.
- Reset mid-run: all registers and outputs are zero after the edge. No tc pulse is emitted.

## Test plan
- Reset and one-shot: assert reset for 2 cycles -> q=0, busy=0, tc=0, expired=0. Then load 5, prescale 0, auto_reload 0, start -> q = 5,4,3,2,1,0 on successive cycles; tc=1 only in the cycle q=0; expired=1, busy=0 afterwards.
- Prescaler: load 3, prescale 2, start -> q steps every 3 cycles; tc at cycle 9 after start; exactly one tc pulse.
- Periodic mode: load 4, prescale 0, auto_reload 1, start -> q = 4,3,2,1,4,3,2,1...; tc every 4 cycles; busy stays 1; expired stays 0.
- Pause and resume: load 6, prescale 0, start; stop when q=2, hold 3 cycles -> q stays 2 and busy=0. Then start -> q = 2,1,0 with tc at the 0.
- Priority and edge cases:
  - load 7 with start in the same cycle -> q=7, busy=0.
  - start with q=0 -> no change, no tc.
  - stop and start together in RUN -> IDLE.
  - load 15, prescale 0 -> tc after 15 cycles.
- Reset mid-operation: reset when q=3 in RUN -> next cycle q=0, busy=0, tc=0, expired=0, reload=0. A start afterwards is ignored until the next load.
